lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
MEM pipeline stage and load/store unit. It receives the registered EX→MEM bundle (LSU request, rd writeback, pc, exception flag) and issues at most one outstanding access on the data-memory req/gnt/rvalid bus. Load data is aligned and sign/zero-extended, and the merged result is registered into the WB stage. It drives ready_mem back to EX and detects misaligned-access and bus-error exceptions.

Parameters:
TAG_WIDTH, 4, width of rd writeback tag carried MEM→WB.

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
flush_M  in  1  kill instruction currently in MEM
ready_wb  in  1  WB can accept
ready_mem  out  1  MEM accepts/advances; EX holds its outputs when low
lsu_en_mem  in  1  instruction is load/store
lsu_op_mem  in  1  0=load, 1=store
lsu_dtype_mem  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr_mem  in  32  effective address
lsu_wdata_mem  in  32  store data, value in low bits
rd_wr_en_mem / rd_wr_tag_mem / rd_wr_addr_mem / rd_wr_data_mem  in  1/TAG_WIDTH/5/32  rd writeback from EX
pc_mem  in  32  instruction pc
exc_taken_mem  in  1  earlier-stage exception
data_req  out  1  bus request
data_gnt  in  1  request accepted
data_addr  out  32  word-aligned address ({addr[31:2],2'b00})
data_we  out  1  store
data_be  out  4  byte enables
data_wdata  out  32  lane-replicated store data
data_rvalid  in  1  response valid, exactly one per granted request
data_rdata  in  32  load data
data_err  in  1  response error, qualified by rvalid
forward_mem_en / forward_mem_tag / forward_mem_addr / forward_mem_wdata  out  1/TAG_WIDTH/5/32  bypass to ID
rd_wr_en_wb / rd_wr_tag_wb / rd_wr_addr_wb / rd_wr_data_wb  out  1/TAG_WIDTH/5/32  registered WB bundle
pc_wb  out  32  registered pc
exc_taken_wb  out  1  registered exception
lsu_exc_cause_wb  out  4  mcause code: 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault; 0 none

Behaviour:
- Reset: every output register is 0, including rd_wr_tag_wb; FSM=IDLE; data_req=0.
- access = lsu_en_mem & ~exc_taken_mem & ~misaligned & ~flush_M. Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- data_be: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'hF. data_wdata: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata. data_we=lsu_op_mem.
- FSM IDLE: data_req=access. With gnt, go to WAIT_RVALID; without gnt, go to WAIT_GNT. Once data_req is raised, it and addr/we/be/wdata stay stable until gnt, even if flush_M arrives.
- WAIT_GNT: data_req=1. On gnt, go to WAIT_RVALID.
- WAIT_RVALID: data_req=0. On rvalid, go to IDLE. Back-to-back: in the rvalid cycle, if the next instruction advances, IDLE-style req may not issue until the following cycle.
- Load result: byte/half selected by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W unchanged.
- ready_mem = ready_wb & (~access_pending | (state==WAIT_RVALID & data_rvalid)). access_pending = access in IDLE, or state≠IDLE. Non-LSU instructions advance in 1 cycle. A granted-in-first-cycle access takes at least 2 cycles.
- WB register update when ready_mem:
  - flush_M, or a flushed_r set: write bubble (rd_wr_en_wb=0, exc_taken_wb=0, cause 0).
  - Otherwise: rd_wr_data_wb = load ? extended rdata : rd_wr_data_mem; rd_wr_en_wb = rd_wr_en_mem & ~exc.
  - exc_taken_wb = exc_taken_mem | misaligned | (rvalid & err). Cause codes per port list; exc_taken_mem alone gives cause 0.
  - pc, tag and addr are always copied.
- When ~ready_mem & ready_wb: WB bundle is cleared to a bubble. When ~ready_wb: all WB registers hold.
- flushed_r: set when flush_M occurs while state≠IDLE or req is outstanding. The in-flight transaction completes on the bus and its rvalid is consumed and discarded. Cleared on that rvalid.
- Forwarding:
  - forward_mem_en = rd_wr_en_mem & ~flush_M & ~exc & (~load | (state==WAIT_RVALID & rvalid & ~err)).
  - forward_mem_wdata is the final WB data value.
- Simultaneous gnt and rvalid for a different request cannot occur (single outstanding).
- Reset mid-transaction aborts the FSM to IDLE; the bus is expected to reset together with the stage.

Test Plan:
- LB at addr 0x103, rdata 0x80FF_1234, gnt same cycle, rvalid +1 → data_req 1 cycle with be=1000; rd_wr_data_wb=0xFFFF_FF80; ready_mem low exactly 1 cycle.
- LHU at 0x202, rdata 0xBEEF_0000 → 0x0000_BEEF. SH wdata 0x1234 at 0x202 → be=1100, data_wdata=0x1234_1234, rd_wr_en_wb=0.
- LW at 0x101 → no data_req; exc_taken_wb=1, cause=4, rd_wr_en_wb=0. SW at 0x102 → cause=6.
- gnt withheld 3 cycles, then rvalid with err=1 → data_req/addr stable 4 cycles, ready_mem low throughout; exc_taken_wb=1, cause=5.
- flush_M in WAIT_RVALID → rvalid absorbed, WB bubble, next load issues only after rvalid.
- ready_wb=0 for 2 cycles on an ALU op → WB registers hold, ready_mem=0; release → advances next edge. Assert reset_n mid-WAIT_GNT → all outputs 0, state IDLE.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the LSU and the memory: req/gnt address phase,
// rvalid/rdata/err response phase, at most one request outstanding.
interface lsu_mem_stage_if;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req,
    output data_addr,
    output data_we,
    output data_be,
    output data_wdata,
    input  data_gnt,
    input  data_rvalid,
    input  data_rdata,
    input  data_err
  );

  modport slave (
    input  data_req,
    input  data_addr,
    input  data_we,
    input  data_be,
    input  data_wdata,
    output data_gnt,
    output data_rvalid,
    output data_rdata,
    output data_err
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM pipeline stage with a single-outstanding load/store unit: issues one bus
// access, aligns/extends load data and registers the merged result into WB.
module lsu_mem_stage #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_M,
  input  logic                 ready_wb,
  output logic                 ready_mem,
  input  logic                 lsu_en_mem,
  input  logic                 lsu_op_mem,
  input  logic [2:0]           lsu_dtype_mem,
  input  logic [31:0]          lsu_addr_mem,
  input  logic [31:0]          lsu_wdata_mem,
  input  logic                 rd_wr_en_mem,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
  input  logic [4:0]           rd_wr_addr_mem,
  input  logic [31:0]          rd_wr_data_mem,
  input  logic [31:0]          pc_mem,
  input  logic                 exc_taken_mem,
  lsu_mem_stage_if.master      data_bus,
  output logic                 forward_mem_en,
  output logic [TAG_WIDTH-1:0] forward_mem_tag,
  output logic [4:0]           forward_mem_addr,
  output logic [31:0]          forward_mem_wdata,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic [31:0]          pc_wb,
  output logic                 exc_taken_wb,
  output logic [3:0]           lsu_exc_cause_wb
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  localparam logic [2:0] DT_B  = 3'b000;
  localparam logic [2:0] DT_H  = 3'b001;
  localparam logic [2:0] DT_W  = 3'b010;
  localparam logic [2:0] DT_BU = 3'b100;
  localparam logic [2:0] DT_HU = 3'b101;

  state_t      state_reg;
  logic        flushed_reg;
  logic [31:0] req_addr_reg;
  logic        req_we_reg;
  logic [3:0]  req_be_reg;
  logic [31:0] req_wdata_reg;
  logic [2:0]  req_dtype_reg;
  logic        resp_held_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  logic        misaligned;
  logic        access;
  logic        in_idle;
  logic        access_pending;
  logic        rvalid_eff;
  logic [31:0] rdata_eff;
  logic        err_eff;
  logic        complete;
  logic        kill;
  logic        is_load;
  logic        is_store;
  logic        bus_err;
  logic        exc_next;
  logic [3:0]  cause_next;
  logic [31:0] wb_data_next;
  logic [3:0]  be_cur;
  logic [31:0] wdata_cur;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [7:0]  lane_byte [4];

  // dtype[1:0] encodes the access size; dtype[2] only selects zero-extension
  always_comb begin
    misaligned = 1'b0;
    be_cur     = 4'hF;
    wdata_cur  = lsu_wdata_mem;
    case (lsu_dtype_mem[1:0])
      2'b00: begin
        be_cur    = 4'b0001 << lsu_addr_mem[1:0];
        wdata_cur = {4{lsu_wdata_mem[7:0]}};
      end
      2'b01: begin
        misaligned = lsu_en_mem & lsu_addr_mem[0];
        be_cur     = 4'b0011 << lsu_addr_mem[1:0];
        wdata_cur  = {2{lsu_wdata_mem[15:0]}};
      end
      default: begin
        misaligned = lsu_en_mem & (|lsu_addr_mem[1:0]);
      end
    endcase
  end

  assign access         = lsu_en_mem & ~exc_taken_mem & ~misaligned & ~flush_M;
  assign in_idle        = (state_reg == IDLE);
  assign access_pending = in_idle ? access : 1'b1;

  // A response that arrived while WB was stalled is parked until WB accepts it
  assign rvalid_eff = (state_reg == WAIT_RVALID) & (data_bus.data_rvalid | resp_held_reg);
  assign rdata_eff  = resp_held_reg ? resp_rdata_reg : data_bus.data_rdata;
  assign err_eff    = resp_held_reg ? resp_err_reg : data_bus.data_err;

  assign ready_mem = ready_wb & (~access_pending | rvalid_eff);
  assign complete  = rvalid_eff & ready_wb;

  // Address phase comes straight from EX in IDLE, then from the latched copy
  assign data_bus.data_req   = in_idle ? access : (state_reg == WAIT_GNT);
  assign data_bus.data_addr  = in_idle ? {lsu_addr_mem[31:2], 2'b00} : {req_addr_reg[31:2], 2'b00};
  assign data_bus.data_we    = in_idle ? lsu_op_mem : req_we_reg;
  assign data_bus.data_be    = in_idle ? be_cur : req_be_reg;
  assign data_bus.data_wdata = in_idle ? wdata_cur : req_wdata_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      flushed_reg    <= 1'b0;
      req_addr_reg   <= '0;
      req_we_reg     <= 1'b0;
      req_be_reg     <= '0;
      req_wdata_reg  <= '0;
      req_dtype_reg  <= '0;
      resp_held_reg  <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access) begin
            req_addr_reg  <= lsu_addr_mem;
            req_we_reg    <= lsu_op_mem;
            req_be_reg    <= be_cur;
            req_wdata_reg <= wdata_cur;
            req_dtype_reg <= lsu_dtype_mem;
            state_reg     <= data_bus.data_gnt ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (data_bus.data_gnt) begin
            state_reg <= WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          if (complete) begin
            state_reg     <= IDLE;
            resp_held_reg <= 1'b0;
          end else if (data_bus.data_rvalid) begin
            resp_held_reg  <= 1'b1;
            resp_rdata_reg <= data_bus.data_rdata;
            resp_err_reg   <= data_bus.data_err;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A killed access still runs to its response, which is then dropped
      if (complete) begin
        flushed_reg <= 1'b0;
      end else if (flush_M && !in_idle) begin
        flushed_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = rdata_eff[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    sel_byte = lane_byte[req_addr_reg[1:0]];
    sel_half = req_addr_reg[1] ? rdata_eff[31:16] : rdata_eff[15:0];
    case (req_dtype_reg)
      DT_B:    load_ext = {{24{sel_byte[7]}}, sel_byte};
      DT_H:    load_ext = {{16{sel_half[15]}}, sel_half};
      DT_BU:   load_ext = {24'h0, sel_byte};
      DT_HU:   load_ext = {16'h0, sel_half};
      DT_W:    load_ext = rdata_eff;
      default: load_ext = rdata_eff;
    endcase
  end

  assign is_load      = lsu_en_mem & ~lsu_op_mem;
  assign is_store     = lsu_en_mem & lsu_op_mem;
  assign kill         = flush_M | flushed_reg;
  assign bus_err      = rvalid_eff & err_eff;
  assign exc_next     = exc_taken_mem | misaligned | bus_err;
  assign wb_data_next = is_load ? load_ext : rd_wr_data_mem;

  // An earlier-stage exception carries its own cause, so it reports 0 here
  always_comb begin
    cause_next = 4'd0;
    if (!exc_taken_mem) begin
      if (misaligned) begin
        cause_next = is_store ? 4'd6 : 4'd4;
      end else if (bus_err) begin
        cause_next = is_store ? 4'd7 : 4'd5;
      end
    end
  end

  assign forward_mem_en    = rd_wr_en_mem & ~kill & ~exc_next &
                             (~is_load | (rvalid_eff & ~err_eff));
  assign forward_mem_tag   = rd_wr_tag_mem;
  assign forward_mem_addr  = rd_wr_addr_mem;
  assign forward_mem_wdata = wb_data_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wr_en_wb      <= 1'b0;
      rd_wr_tag_wb     <= '0;
      rd_wr_addr_wb    <= '0;
      rd_wr_data_wb    <= '0;
      pc_wb            <= '0;
      exc_taken_wb     <= 1'b0;
      lsu_exc_cause_wb <= '0;
    end else if (ready_wb) begin
      pc_wb         <= pc_mem;
      rd_wr_tag_wb  <= rd_wr_tag_mem;
      rd_wr_addr_wb <= rd_wr_addr_mem;
      rd_wr_data_wb <= wb_data_next;
      if (ready_mem && !kill) begin
        rd_wr_en_wb      <= rd_wr_en_mem & ~exc_next;
        exc_taken_wb     <= exc_next;
        lsu_exc_cause_wb <= cause_next;
      end else begin
        rd_wr_en_wb      <= 1'b0;
        exc_taken_wb     <= 1'b0;
        lsu_exc_cause_wb <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: hand-computed loads, stores, exceptions,
// flush, WB back-pressure and asynchronous reset in the middle of an access.
module tb_lsu_mem_stage;

  localparam int TW = 4;
  localparam logic [2:0] DT_B  = 3'b000;
  localparam logic [2:0] DT_H  = 3'b001;
  localparam logic [2:0] DT_W  = 3'b010;
  localparam logic [2:0] DT_BU = 3'b100;
  localparam logic [2:0] DT_HU = 3'b101;

  logic          clk;
  logic          reset_n;
  logic          flush_M;
  logic          ready_wb;
  logic          ready_mem;
  logic          lsu_en_mem;
  logic          lsu_op_mem;
  logic [2:0]    lsu_dtype_mem;
  logic [31:0]   lsu_addr_mem;
  logic [31:0]   lsu_wdata_mem;
  logic          rd_wr_en_mem;
  logic [TW-1:0] rd_wr_tag_mem;
  logic [4:0]    rd_wr_addr_mem;
  logic [31:0]   rd_wr_data_mem;
  logic [31:0]   pc_mem;
  logic          exc_taken_mem;
  logic          forward_mem_en;
  logic [TW-1:0] forward_mem_tag;
  logic [4:0]    forward_mem_addr;
  logic [31:0]   forward_mem_wdata;
  logic          rd_wr_en_wb;
  logic [TW-1:0] rd_wr_tag_wb;
  logic [4:0]    rd_wr_addr_wb;
  logic [31:0]   rd_wr_data_wb;
  logic [31:0]   pc_wb;
  logic          exc_taken_wb;
  logic [3:0]    lsu_exc_cause_wb;

  int tests_run;
  int tests_failed;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TAG_WIDTH(TW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush_M           (flush_M),
    .ready_wb          (ready_wb),
    .ready_mem         (ready_mem),
    .lsu_en_mem        (lsu_en_mem),
    .lsu_op_mem        (lsu_op_mem),
    .lsu_dtype_mem     (lsu_dtype_mem),
    .lsu_addr_mem      (lsu_addr_mem),
    .lsu_wdata_mem     (lsu_wdata_mem),
    .rd_wr_en_mem      (rd_wr_en_mem),
    .rd_wr_tag_mem     (rd_wr_tag_mem),
    .rd_wr_addr_mem    (rd_wr_addr_mem),
    .rd_wr_data_mem    (rd_wr_data_mem),
    .pc_mem            (pc_mem),
    .exc_taken_mem     (exc_taken_mem),
    .data_bus          (bus),
    .forward_mem_en    (forward_mem_en),
    .forward_mem_tag   (forward_mem_tag),
    .forward_mem_addr  (forward_mem_addr),
    .forward_mem_wdata (forward_mem_wdata),
    .rd_wr_en_wb       (rd_wr_en_wb),
    .rd_wr_tag_wb      (rd_wr_tag_wb),
    .rd_wr_addr_wb     (rd_wr_addr_wb),
    .rd_wr_data_wb     (rd_wr_data_wb),
    .pc_wb             (pc_wb),
    .exc_taken_wb      (exc_taken_wb),
    .lsu_exc_cause_wb  (lsu_exc_cause_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "bench did not complete");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_M         = 1'b0;
    lsu_en_mem      = 1'b0;
    lsu_op_mem      = 1'b0;
    lsu_dtype_mem   = DT_W;
    lsu_addr_mem    = 32'h0;
    lsu_wdata_mem   = 32'h0;
    rd_wr_en_mem    = 1'b0;
    rd_wr_tag_mem   = '0;
    rd_wr_addr_mem  = 5'd0;
    rd_wr_data_mem  = 32'h0;
    exc_taken_mem   = 1'b0;
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 32'h0;
    bus.data_err    = 1'b0;
  endtask

  task automatic present(input logic op, input logic [2:0] dt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] pc);
    lsu_en_mem     = 1'b1;
    lsu_op_mem     = op;
    lsu_dtype_mem  = dt;
    lsu_addr_mem   = addr;
    lsu_wdata_mem  = wdata;
    rd_wr_en_mem   = ~op;
    rd_wr_tag_mem  = 4'hA;
    rd_wr_addr_mem = 5'd7;
    rd_wr_data_mem = 32'hDEAD_0000;
    pc_mem         = pc;
  endtask

  // Full access: gnt after gnt_wait stall cycles, rvalid the cycle after gnt
  task automatic run_lsu(input string name, input logic op, input logic [2:0] dt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input int gnt_wait,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] pc);
    logic [31:0] addr_al;
    addr_al = {addr[31:2], 2'b00};
    present(op, dt, addr, wdata, pc);
    for (int i = 0; i <= gnt_wait; i++) begin
      bus.data_gnt = (i == gnt_wait);
      #1;
      check({name, "_req"}, bus.data_req, 1'b1);
      check({name, "_addr"}, bus.data_addr, addr_al);
      check({name, "_be"}, bus.data_be, exp_be);
      check({name, "_we"}, bus.data_we, op);
      if (op) check({name, "_wdata"}, bus.data_wdata, exp_wdata);
      check({name, "_rdy_low"}, ready_mem, 1'b0);
      tick();
    end
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = rdata;
    bus.data_err    = err;
    #1;
    check({name, "_req_done"}, bus.data_req, 1'b0);
    check({name, "_rdy_high"}, ready_mem, 1'b1);
    tick();
    idle_inputs();
    check({name, "_pc_wb"}, pc_wb, pc);
    $display("[TB] %s addr=0x%08h wb_en=%0d wb_data=0x%08h exc=%0d cause=%0d",
             name, addr, rd_wr_en_wb, rd_wr_data_wb, exc_taken_wb, lsu_exc_cause_wb);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    ready_wb     = 1'b1;
    pc_mem       = 32'h0;
    idle_inputs();
    tick();
    tick();
    check("rst_req", bus.data_req, 1'b0);
    check("rst_wb_en", rd_wr_en_wb, 1'b0);
    check("rst_tag", rd_wr_tag_wb, 4'h0);
    check("rst_pc", pc_wb, 32'h0);
    check("rst_exc", exc_taken_wb, 1'b0);
    check("rst_rdy", ready_mem, 1'b1);
    reset_n = 1'b1;
    tick();
    $display("[TB] reset released");

    // LB: lane 3 byte 0x80 sign-extended; forwarded during the rvalid cycle
    present(1'b0, DT_B, 32'h103, 32'h0, 32'h1000);
    bus.data_gnt = 1'b1;
    #1;
    check("lb_req", bus.data_req, 1'b1);
    check("lb_be", bus.data_be, 4'b1000);
    check("lb_addr", bus.data_addr, 32'h100);
    check("lb_rdy0", ready_mem, 1'b0);
    tick();
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h80FF_1234;
    #1;
    check("lb_req1", bus.data_req, 1'b0);
    check("lb_rdy1", ready_mem, 1'b1);
    check("lb_fwd_en", forward_mem_en, 1'b1);
    check("lb_fwd_data", forward_mem_wdata, 32'hFFFF_FF80);
    tick();
    idle_inputs();
    check("lb_data", rd_wr_data_wb, 32'hFFFF_FF80);
    check("lb_en", rd_wr_en_wb, 1'b1);
    check("lb_rd", rd_wr_addr_wb, 5'd7);
    check("lb_tag", rd_wr_tag_wb, 4'hA);
    check("lb_exc", exc_taken_wb, 1'b0);
    $display("[TB] LB addr=0x00000103 wb_data=0x%08h", rd_wr_data_wb);

    run_lsu("lhu", 1'b0, DT_HU, 32'h202, 32'h0, 32'hBEEF_0000, 1'b0, 0, 4'b1100, 32'h0, 32'h1004);
    check("lhu_data", rd_wr_data_wb, 32'h0000_BEEF);
    check("lhu_en", rd_wr_en_wb, 1'b1);

    run_lsu("lh", 1'b0, DT_H, 32'h202, 32'h0, 32'h8001_0000, 1'b0, 0, 4'b1100, 32'h0, 32'h1008);
    check("lh_data", rd_wr_data_wb, 32'hFFFF_8001);

    run_lsu("lbu", 1'b0, DT_BU, 32'h101, 32'h0, 32'h0000_F700, 1'b0, 0, 4'b0010, 32'h0, 32'h100C);
    check("lbu_data", rd_wr_data_wb, 32'h0000_00F7);

    run_lsu("lw", 1'b0, DT_W, 32'h104, 32'h0, 32'h1234_5678, 1'b0, 0, 4'hF, 32'h0, 32'h1010);
    check("lw_data", rd_wr_data_wb, 32'h1234_5678);

    run_lsu("sh", 1'b1, DT_H, 32'h202, 32'h0000_1234, 32'h0, 1'b0, 0, 4'b1100, 32'h1234_1234, 32'h1014);
    check("sh_en", rd_wr_en_wb, 1'b0);
    check("sh_exc", exc_taken_wb, 1'b0);

    run_lsu("sb", 1'b1, DT_B, 32'h201, 32'h0000_00AB, 32'h0, 1'b0, 0, 4'b0010, 32'hABAB_ABAB, 32'h1018);

    // Misaligned: no bus activity, single-cycle advance with an exception
    present(1'b0, DT_W, 32'h101, 32'h0, 32'h1020);
    #1;
    check("lw_mis_req", bus.data_req, 1'b0);
    check("lw_mis_rdy", ready_mem, 1'b1);
    tick();
    idle_inputs();
    check("lw_mis_exc", exc_taken_wb, 1'b1);
    check("lw_mis_cause", lsu_exc_cause_wb, 4'd4);
    check("lw_mis_en", rd_wr_en_wb, 1'b0);
    $display("[TB] LW misaligned cause=%0d", lsu_exc_cause_wb);

    present(1'b1, DT_W, 32'h102, 32'h5555_AAAA, 32'h1024);
    #1;
    check("sw_mis_req", bus.data_req, 1'b0);
    tick();
    idle_inputs();
    check("sw_mis_exc", exc_taken_wb, 1'b1);
    check("sw_mis_cause", lsu_exc_cause_wb, 4'd6);
    $display("[TB] SW misaligned cause=%0d", lsu_exc_cause_wb);

    // Grant withheld three cycles, then an error response
    run_lsu("lw_err", 1'b0, DT_W, 32'h240, 32'h0, 32'h0, 1'b1, 3, 4'hF, 32'h0, 32'h1028);
    check("lw_err_exc", exc_taken_wb, 1'b1);
    check("lw_err_cause", lsu_exc_cause_wb, 4'd5);
    check("lw_err_en", rd_wr_en_wb, 1'b0);

    // Flush while waiting for rvalid: response absorbed, WB sees bubbles
    present(1'b0, DT_W, 32'h300, 32'h0, 32'h1030);
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    flush_M      = 1'b1;
    #1;
    check("fl_rdy", ready_mem, 1'b0);
    check("fl_fwd", forward_mem_en, 1'b0);
    tick();
    flush_M = 1'b0;
    check("fl_bubble_en", rd_wr_en_wb, 1'b0);
    #1;
    check("fl_no_reissue", bus.data_req, 1'b0);
    check("fl_rdy_wait", ready_mem, 1'b0);
    tick();
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'hCAFE_F00D;
    #1;
    check("fl_rdy_rvalid", ready_mem, 1'b1);
    check("fl_fwd_rvalid", forward_mem_en, 1'b0);
    tick();
    idle_inputs();
    check("fl_wb_en", rd_wr_en_wb, 1'b0);
    check("fl_wb_exc", exc_taken_wb, 1'b0);
    $display("[TB] flushed LW absorbed wb_en=%0d", rd_wr_en_wb);
    run_lsu("lw_after_fl", 1'b0, DT_W, 32'h400, 32'h0, 32'h0BAD_BEEF, 1'b0, 0, 4'hF, 32'h0, 32'h1034);
    check("lw_after_fl_data", rd_wr_data_wb, 32'h0BAD_BEEF);
    check("lw_after_fl_en", rd_wr_en_wb, 1'b1);

    // WB back-pressure on ALU ops
    rd_wr_en_mem   = 1'b1;
    rd_wr_addr_mem = 5'd9;
    rd_wr_data_mem = 32'h0000_A5A5;
    pc_mem         = 32'h1040;
    tick();
    check("alu_data", rd_wr_data_wb, 32'h0000_A5A5);
    check("alu_en", rd_wr_en_wb, 1'b1);
    rd_wr_data_mem = 32'h0000_1111;
    pc_mem         = 32'h1044;
    ready_wb       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_rdy", ready_mem, 1'b0);
      tick();
      check("stall_hold_data", rd_wr_data_wb, 32'h0000_A5A5);
      check("stall_hold_pc", pc_wb, 32'h1040);
    end
    ready_wb = 1'b1;
    #1;
    check("stall_release_rdy", ready_mem, 1'b1);
    tick();
    check("stall_release_data", rd_wr_data_wb, 32'h0000_1111);
    check("stall_release_pc", pc_wb, 32'h1044);
    idle_inputs();
    $display("[TB] ALU op held 2 cycles then wb_data=0x%08h", rd_wr_data_wb);

    // Asynchronous reset in WAIT_GNT
    present(1'b0, DT_W, 32'h500, 32'h0, 32'h1050);
    tick();
    check("rst_mid_req", bus.data_req, 1'b1);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check("rst_mid_req0", bus.data_req, 1'b0);
    check("rst_mid_pc", pc_wb, 32'h0);
    check("rst_mid_tag", rd_wr_tag_wb, 4'h0);
    check("rst_mid_en", rd_wr_en_wb, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_mid_idle", bus.data_req, 1'b0);
    check("rst_mid_rdy", ready_mem, 1'b1);
    $display("[TB] reset during WAIT_GNT returned to idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
